// File: rtl/fact_pkg.sv
// Shared types and defaults for the factorial datapath blocks.
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam int FACT_W = 4;

endpackage

// File: rtl/fact_sat_sub.sv
// Saturating subtract of a constant step: result clamps at zero instead of wrapping.
module fact_sat_sub #(
    parameter int          WIDTH = fact_pkg::FACT_W,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] nxt,
    output logic             uflow
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    always_comb begin
        uflow = (a < STEP_W);
        nxt   = uflow ? '0 : (a - STEP_W);
    end

endmodule

// File: rtl/fact_dn_counter.sv
// Loadable down-counter with terminal-count detection; sequences the factorial
// multiply iterations (IDLE -> RUN -> DONE).
module fact_dn_counter
    import fact_pkg::*;
#(
    parameter int          WIDTH = FACT_W,
    parameter int unsigned STEP  = 1,
    parameter int unsigned FLOOR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             gt,
    output logic             busy,
    output logic             tc
);

    localparam logic [WIDTH-1:0] FLOOR_W = WIDTH'(FLOOR);

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] nxt;
    logic             uflow;

    fact_sat_sub #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_sat_sub (
        .a     (cnt_q),
        .nxt   (nxt),
        .uflow (uflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
        end
    end

    // Priority clr > ld > en; a load always restarts and drops any pending terminal event.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (ld) begin
            cnt_d = n;
            if (n > FLOOR_W) begin
                state_d = RUN;
            end else begin
                state_d = DONE;
                tc_d    = 1'b1;
            end
        end else if (en && (state_q == RUN)) begin
            cnt_d = nxt;
            if (uflow || (nxt <= FLOOR_W)) begin
                state_d = DONE;
                tc_d    = 1'b1;
            end
        end
    end

    assign cnt  = cnt_q;
    assign tc   = tc_q;
    assign busy = (state_q == RUN);
    assign gt   = (cnt_q > FLOOR_W);

endmodule

// File: tb/tb_fact_dn_counter.sv
// Bench for fact_dn_counter: two instances (STEP=1/FLOOR=1 and STEP=3/FLOOR=0)
// driven in lockstep, checked against a plain-arithmetic reference model.
module tb_fact_dn_counter;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       ld;
    logic [3:0] n;
    logic       en;

    logic [3:0] cnt_a, cnt_b;
    logic       gt_a, gt_b, busy_a, busy_b, tc_a, tc_b;

    int n_chk;
    int n_bad;

    // reference model state per instance: 0 = STEP1/FLOOR1, 1 = STEP3/FLOOR0
    int m_cnt  [2];
    bit m_run  [2];
    bit m_tc   [2];
    int m_step [2] = '{1, 3};
    int m_floor[2] = '{1, 0};

    fact_dn_counter #(.WIDTH(4), .STEP(1), .FLOOR(1)) u_a (
        .clk (clk), .rst_n (rst_n), .clr (clr), .ld (ld), .n (n), .en (en),
        .cnt (cnt_a), .gt (gt_a), .busy (busy_a), .tc (tc_a)
    );

    fact_dn_counter #(.WIDTH(4), .STEP(3), .FLOOR(0)) u_b (
        .clk (clk), .rst_n (rst_n), .clr (clr), .ld (ld), .n (n), .en (en),
        .cnt (cnt_b), .gt (gt_b), .busy (busy_b), .tc (tc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_run[i] = 1'b0;
            m_tc[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_tc[i] = 1'b0;
            if (clr) begin
                m_cnt[i] = 0;
                m_run[i] = 1'b0;
            end else if (ld) begin
                m_cnt[i] = int'(n);
                m_run[i] = (m_cnt[i] > m_floor[i]);
                m_tc[i]  = !m_run[i];
            end else if (en && m_run[i]) begin
                m_cnt[i] = (m_cnt[i] >= m_step[i]) ? m_cnt[i] - m_step[i] : 0;
                if (m_cnt[i] <= m_floor[i]) begin
                    m_run[i] = 1'b0;
                    m_tc[i]  = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("a.cnt",  32'(cnt_a),  32'(m_cnt[0]));
        check("a.busy", 32'(busy_a), 32'(m_run[0]));
        check("a.tc",   32'(tc_a),   32'(m_tc[0]));
        check("a.gt",   32'(gt_a),   32'(m_cnt[0] > m_floor[0]));
        check("b.cnt",  32'(cnt_b),  32'(m_cnt[1]));
        check("b.busy", 32'(busy_b), 32'(m_run[1]));
        check("b.tc",   32'(tc_b),   32'(m_tc[1]));
        check("b.gt",   32'(gt_b),   32'(m_cnt[1] > m_floor[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic drive(input bit c, input bit l, input int v, input bit e);
        clr = c;
        ld  = l;
        n   = 4'(v);
        en  = e;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #12;
        check("rst.cnt",  32'(cnt_a),  0);
        check("rst.busy", 32'(busy_a), 0);
        check("rst.tc",   32'(tc_a),   0);
        check("rst.gt",   32'(gt_a),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // normal count from 5
        drive(0, 1, 5, 0);
        tick();
        check("norm.cnt5", 32'(cnt_a), 5);
        drive(0, 0, 0, 1);
        for (int k = 4; k >= 1; k--) begin
            check("norm.busy", 32'(busy_a), 1);
            tick();
            check("norm.seq", 32'(cnt_a), 32'(k));
        end
        check("norm.tc",   32'(tc_a),   1);
        check("norm.busy0", 32'(busy_a), 0);
        check("norm.gt",   32'(gt_a),   0);
        // b instance (STEP=3, FLOOR=0) loaded 5 too: 5 -> 2 -> 0
        check("sat5.cnt", 32'(cnt_b), 0);

        // degenerate loads
        drive(0, 1, 0, 0);
        tick();
        check("deg0.tc",  32'(tc_a),   1);
        check("deg0.cnt", 32'(cnt_a),  0);
        drive(0, 1, 1, 0);
        tick();
        check("deg1.tc",   32'(tc_a),   1);
        check("deg1.busy", 32'(busy_a), 0);
        drive(0, 0, 0, 0);
        tick();
        check("deg1.tc0", 32'(tc_a), 0);

        // priority: ld beats en, clr beats ld
        drive(0, 1, 5, 0);
        tick();
        drive(0, 0, 0, 1);
        tick();
        tick();
        check("pri.at3", 32'(cnt_a), 3);
        drive(0, 1, 7, 1);
        tick();
        check("pri.ld7",   32'(cnt_a),  7);
        check("pri.run",   32'(busy_a), 1);
        drive(1, 1, 9, 1);
        tick();
        check("pri.clr",   32'(cnt_a),  0);
        check("pri.idle",  32'(busy_a), 0);

        // saturation on b: 7,4,1,0 with no wrap
        drive(0, 1, 7, 0);
        tick();
        drive(0, 0, 0, 1);
        tick();
        check("sat.4", 32'(cnt_b), 4);
        tick();
        check("sat.1", 32'(cnt_b), 1);
        tick();
        check("sat.0",  32'(cnt_b), 0);
        check("sat.tc", 32'(tc_b),  1);

        // gaps and hold in DONE
        drive(0, 1, 4, 0);
        tick();
        drive(0, 0, 0, 1); tick(); check("gap.3a", 32'(cnt_a), 3);
        drive(0, 0, 0, 0); tick(); check("gap.3b", 32'(cnt_a), 3);
        drive(0, 0, 0, 1); tick(); check("gap.2",  32'(cnt_a), 2);
        tick();
        check("gap.done", 32'(tc_a), 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold.cnt", 32'(cnt_a), 1);
            check("hold.tc",  32'(tc_a),  0);
        end

        // asynchronous reset mid-RUN
        drive(0, 1, 12, 0);
        tick();
        drive(0, 0, 0, 1);
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("arst.cnt", 32'(cnt_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fact_dn_counter.md
# fact_dn_counter

Parametrised loadable down-counter with terminal-count detection for the factorial datapath. It loads the operand `n`, decrements by `STEP` on each enabled cycle, and reports when the count reaches or crosses the terminal value `FLOOR`. The controller FSM uses it to sequence multiply iterations. Compared with the fixed 4-bit counter, it adds reset, a sequencing FSM, a saturating step, a compare flag, a done pulse and a busy status.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits; legal range 2–32.
- `STEP`, 1: decrement amount; 1 ≤ STEP < 2^WIDTH.
- `FLOOR`, 1: terminal value; 0 ≤ FLOOR < 2^WIDTH.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `clr`, in, 1: synchronous clear to IDLE; highest synchronous priority.
- `ld`, in, 1: load `n` this cycle.
- `n`, in, WIDTH: load value.
- `en`, in, 1: decrement request.
- `cnt`, out, WIDTH: current count.
- `gt`, out, 1: `cnt > FLOOR`, combinational from `cnt`.
- `busy`, out, 1: state is RUN.
- `tc`, out, 1: terminal-count pulse, one cycle, registered.

## Operation
- States:
  - IDLE: reset/clear state.
  - RUN: counting.
  - DONE: terminal value reached; holds until the next `ld` or `clr`.
- Reset (`rst_n`=0, asynchronous): state IDLE, `cnt`=0, `tc`=0, `busy`=0, `gt`=0.
- Priority per edge: `clr` > `ld` > `en`.
- `clr`: state IDLE, `cnt`=0, `tc`=0.
- `ld` (any state):
  - `cnt` ← `n`.
  - If `n` > FLOOR, go to RUN with `tc`=0.
  - Else go to DONE with `tc`=1 for one cycle (degenerate operand, e.g. 0! or 1!).
- `en` in RUN without `ld`:
  - If `cnt` ≥ STEP, `nxt` = `cnt` − STEP; otherwise `nxt` = 0 (saturate, never wrap).
  - `cnt` ← `nxt`.
  - If `nxt` ≤ FLOOR, go to DONE and pulse `tc`.
- `en` in IDLE or DONE: ignored; `cnt` holds.
- `ld` and `en` in the same cycle: load wins; no decrement is applied to the loaded value.
- `ld` in RUN: restart; any pending terminal event is discarded.
- All subtraction and comparison are unsigned at WIDTH bits. No intermediate value exceeds WIDTH.

## Timing
- All state and `cnt` updates occur on the `clk` rising edge after `ld`/`en` are sampled.
- Latency: one cycle from input to `cnt`.
- `tc` is high exactly in the cycle after the edge at which the transition to DONE is taken. It is low otherwise, including while the block stays in DONE.
- `busy` is registered: high for every cycle in RUN, and falls in the same cycle `tc` rises.
- `gt` follows `cnt` combinationally, with no added latency.
- Iteration count from load: ceil((n − FLOOR)/STEP) enabled cycles, for n > FLOOR.
- Reset deasserted mid-operation: the block restarts in IDLE and needs a fresh `ld`.
- `rst_n` assertion is effective immediately, independent of `clk`.

## Structure
- Shared package `fact_pkg`:
  - `typedef enum` `cnt_state_t` {IDLE, RUN, DONE}.
  - Default width constant `FACT_W` = 4.
- Sub-module `fact_sat_sub` (WIDTH, STEP): combinational saturating subtractor producing `nxt` and an `uflow` flag. This logic is reused by the multiplier-operand path.
- The top level holds the FSM, the `cnt` register, the `tc` register and the `gt` compare.

## Test plan
All scenarios use WIDTH=4, STEP=1, FLOOR=1 unless stated otherwise.
- Reset: assert `rst_n`=0 asynchronously mid-RUN → `cnt`=0, `busy`=0, `tc`=0, `gt`=0 immediately, without waiting for a clock edge.
- Normal count: `ld` with `n`=5, then `en` held high → `cnt` sequence 5,4,3,2,1; `busy` high for 4 cycles; `tc` high one cycle with `cnt`=1; `gt`=0 in DONE.
- Degenerate load: `ld` with `n`=0 → DONE, `cnt`=0, `tc` pulse. Same result with `n`=1: `cnt`=1, `tc` pulse, `busy` never asserts.
- Priority: in RUN at `cnt`=3, assert `ld` (`n`=7) and `en` together → `cnt`=7 and state RUN. Next cycle, `clr`+`ld` together → IDLE, `cnt`=0.
- Saturation: STEP=3, FLOOR=0, `n`=7 → `cnt` sequence 7,4,1,0; `tc` pulses with `cnt`=0; no wrap to 14.
- Gaps and hold: `en` toggled 1,0,1 in RUN from `n`=4 → `cnt` sequence 4,3,3,2. In DONE, `en`=1 for 5 cycles → `cnt` holds and `tc` stays 0 after its single pulse.
